// File: rtl/vga_pkg.sv
// Shared VGA text-box geometry, timing bundle and animation phase types.
package vga_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned CHAR_H = 16;
    localparam int unsigned GRID   = 16;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned HC_W   = 11;
    localparam int unsigned BOX_W  = GRID * CHAR_W;
    localparam int unsigned BOX_H  = GRID * CHAR_H;

    typedef struct packed {
        logic [HC_W-1:0] hcount;
        logic            hsync;
        logic            hblnk;
        logic [HC_W-1:0] vcount;
        logic            vsync;
        logic            vblnk;
    } vga_timing_t;

    localparam int unsigned TIMING_W = $bits(vga_timing_t);

    typedef enum logic [1:0] {
        PHASE_0,
        PHASE_1,
        PHASE_2,
        PHASE_3
    } anim_phase_t;

endpackage

// File: rtl/text_anim_ctl.sv
// Dot animation controller: counts vsync rising edges and steps the visible-dot phase.
module text_anim_ctl
    import vga_pkg::*;
#(
    parameter logic [1:0] DOT_NUM     = 2'd3,
    parameter logic [5:0] ANIM_FRAMES = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       vsync_in,
    output logic [1:0] phase
);

    anim_phase_t state;
    logic [5:0]  frame_cnt;
    logic        vsync_prev;

    // Disabling the overlay restarts the animation and takes priority over a frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PHASE_0;
            frame_cnt  <= 6'd0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (!enable) begin
                state     <= PHASE_0;
                frame_cnt <= 6'd0;
            end else if (vsync_in && !vsync_prev) begin
                if (frame_cnt == ANIM_FRAMES - 6'd1) begin
                    frame_cnt <= 6'd0;
                    state     <= (2'(state) == DOT_NUM) ? PHASE_0
                                                        : anim_phase_t'(2'(state) + 2'd1);
                end else begin
                    frame_cnt <= frame_cnt + 6'd1;
                end
            end
        end
    end

    assign phase = 2'(state);

endmodule

// File: rtl/text_box_seq.sv
// 16x16 character text-box overlay: char ROM and font ROM lookups aligned to a 4-cycle pipeline.
module text_box_seq
    import vga_pkg::*;
#(
    parameter logic [HC_W-1:0]  XPOS        = 11'd448,
    parameter logic [HC_W-1:0]  YPOS        = 11'd256,
    parameter logic [RGB_W-1:0] TEXT_RGB    = 12'hFFF,
    parameter logic [3:0]       DOT_COL     = 4'd7,
    parameter logic [1:0]       DOT_NUM     = 2'd3,
    parameter logic [5:0]       ANIM_FRAMES = 6'd30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [HC_W-1:0]  hcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic [HC_W-1:0]  vcount_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [7:0]       char_xy,
    input  logic [6:0]       char_code_in,
    output logic [10:0]      font_addr,
    input  logic [7:0]       font_row_in,
    output logic [HC_W-1:0]  hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [HC_W-1:0]  vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out
);

    localparam logic [HC_W-1:0] X_END = XPOS + HC_W'(BOX_W);
    localparam logic [HC_W-1:0] Y_END = YPOS + HC_W'(BOX_H);

    logic [1:0] phase;

    text_anim_ctl #(
        .DOT_NUM     (DOT_NUM),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .vsync_in (vsync_in),
        .phase    (phase)
    );

    // Stage-1 address decode; only the low bits of the box-relative position matter.
    logic [6:0]          rel_x;
    logic [7:0]          rel_y;
    logic [3:0]          col, row, k;
    logic                in_box_c, dot_hide_c;
    logic [TIMING_W-1:0] tim_in;

    assign rel_x    = 7'(hcount_in - XPOS);
    assign rel_y    = 8'(vcount_in - YPOS);
    assign col      = rel_x[6:3];
    assign row      = rel_y[7:4];
    assign k        = col - DOT_COL;
    assign in_box_c = (hcount_in >= XPOS) && (hcount_in < X_END) &&
                      (vcount_in >= YPOS) && (vcount_in < Y_END);
    assign dot_hide_c = (row == 4'd0) && (col >= DOT_COL) &&
                        ({1'b0, col} < (5'(DOT_COL) + 5'(DOT_NUM))) &&
                        (k >= {2'b00, phase});
    assign tim_in   = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

    logic [3:0]       line_d1, line_d2;
    logic [2:0]       xoff_d1, xoff_d2, xoff_d3;
    logic             in_box_d1, in_box_d2, in_box_d3;
    logic             hide_d1, hide_d2, hide_d3;
    logic             en_d1, en_d2, en_d3;
    logic [RGB_W-1:0] rgb_d1, rgb_d2, rgb_d3;
    vga_timing_t      tim_d1, tim_d2, tim_d3, tim_d4;
    logic             pix;

    assign font_addr = {char_code_in, line_d2};
    assign pix       = font_row_in[3'd7 - xoff_d3];

    always_ff @(posedge clk) begin
        if (rst) begin
            char_xy   <= 8'h00;
            line_d1   <= 4'd0;  line_d2   <= 4'd0;
            xoff_d1   <= 3'd0;  xoff_d2   <= 3'd0;  xoff_d3   <= 3'd0;
            in_box_d1 <= 1'b0;  in_box_d2 <= 1'b0;  in_box_d3 <= 1'b0;
            hide_d1   <= 1'b0;  hide_d2   <= 1'b0;  hide_d3   <= 1'b0;
            en_d1     <= 1'b0;  en_d2     <= 1'b0;  en_d3     <= 1'b0;
            rgb_d1    <= '0;    rgb_d2    <= '0;    rgb_d3    <= '0;
            tim_d1    <= '0;    tim_d2    <= '0;    tim_d3    <= '0;
            tim_d4    <= '0;
            rgb_out   <= '0;
        end else begin
            char_xy   <= {row, col};
            line_d1   <= rel_y[3:0];
            xoff_d1   <= rel_x[2:0];
            in_box_d1 <= in_box_c;
            hide_d1   <= dot_hide_c;
            en_d1     <= enable;
            rgb_d1    <= rgb_in;
            tim_d1    <= vga_timing_t'(tim_in);

            line_d2   <= line_d1;
            xoff_d2   <= xoff_d1;   xoff_d3   <= xoff_d2;
            in_box_d2 <= in_box_d1; in_box_d3 <= in_box_d2;
            hide_d2   <= hide_d1;   hide_d3   <= hide_d2;
            en_d2     <= en_d1;     en_d3     <= en_d2;
            rgb_d2    <= rgb_d1;    rgb_d3    <= rgb_d2;
            tim_d2    <= tim_d1;    tim_d3    <= tim_d2;
            tim_d4    <= tim_d3;

            // Blanking forces black regardless of overlay state.
            if (tim_d3.hblnk || tim_d3.vblnk)
                rgb_out <= '0;
            else if (en_d3 && in_box_d3 && pix && !hide_d3)
                rgb_out <= TEXT_RGB;
            else
                rgb_out <= rgb_d3;
        end
    end

    assign hcount_out = tim_d4.hcount;
    assign hsync_out  = tim_d4.hsync;
    assign hblnk_out  = tim_d4.hblnk;
    assign vcount_out = tim_d4.vcount;
    assign vsync_out  = tim_d4.vsync;
    assign vblnk_out  = tim_d4.vblnk;

endmodule

// File: tb/tb_text_box_seq.sv
// Scoreboard bench for text_box_seq with behavioural char-code and font ROMs.
module tb_text_box_seq;

    localparam logic [10:0] XPOS     = 11'd448;
    localparam logic [10:0] YPOS     = 11'd256;
    localparam logic [11:0] TEXT_RGB = 12'hFFF;
    localparam int          LAT      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_xy;
    logic [6:0]  char_code_in;
    logic [10:0] font_addr;
    logic [7:0]  font_row_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    text_box_seq #(.ANIM_FRAMES(6'd2)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_xy(char_xy), .char_code_in(char_code_in),
        .font_addr(font_addr), .font_row_in(font_row_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code_of(input logic [7:0] xy);
        return 7'(xy * 8'd37);
    endfunction

    // Line 15 of every glyph is solid so dot and edge cells have a known lit pixel.
    function automatic logic [7:0] font_of(input logic [10:0] a);
        if (a == {code_of(8'h23), 4'h5}) return 8'b0010_0000;
        if (a[3:0] == 4'hF) return 8'hFF;
        return 8'(a * 11'd53) ^ 8'(a >> 3);
    endfunction

    always @(posedge clk) begin
        char_code_in <= code_of(char_xy);
        font_row_in  <= font_of(font_addr);
    end

    typedef struct packed {
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb;
        logic        en;
    } px_t;

    typedef struct {
        logic [11:0] rgb;
        logic [25:0] tim;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_frame = 0, m_phase = 0;
    logic m_vprev = 1'b0;

    function automatic px_t mk(input logic [10:0] h, v, input logic hb, vb, vs, en);
        px_t p;
        p.h = h; p.v = v; p.hs = 1'b0; p.hb = hb; p.vs = vs; p.vb = vb; p.en = en;
        p.rgb = 12'($urandom_range(0, 4094));
        return p;
    endfunction

    // Drives one pixel and pushes the output the specification predicts for it.
    task automatic drive_px(input px_t p, input string name);
        exp_t        e;
        logic [10:0] rx, ry;
        logic [3:0]  col, row;
        logic [7:0]  frow;
        logic        inb, pix, hide;
        int          k;
        hcount_in = p.h; vcount_in = p.v; hsync_in = p.hs; hblnk_in = p.hb;
        vsync_in = p.vs; vblnk_in = p.vb; rgb_in = p.rgb; enable = p.en;
        e.name = name;
        if (rst) begin
            e.rgb = '0; e.tim = '0;
            m_frame = 0; m_phase = 0; m_vprev = 1'b0;
        end else begin
            rx   = p.h - XPOS;
            ry   = p.v - YPOS;
            inb  = (p.h >= XPOS) && (p.h < XPOS + 11'd128) && (p.v >= YPOS) && (p.v < YPOS + 11'd256);
            col  = rx[6:3];
            row  = ry[7:4];
            frow = font_of({code_of({row, col}), ry[3:0]});
            pix  = frow[3'd7 - rx[2:0]];
            k    = int'(col) - 7;
            hide = (row == 4'd0) && (k >= 0) && (k < 3) && (k >= m_phase);
            if (p.hb || p.vb) e.rgb = 12'h000;
            else if (p.en && inb && pix && !hide) e.rgb = TEXT_RGB;
            else e.rgb = p.rgb;
            e.tim = {p.h, p.hs, p.hb, p.v, p.vs, p.vb};
            if (!p.en) begin
                m_frame = 0; m_phase = 0;
            end else if (p.vs && !m_vprev) begin
                if (m_frame == 1) begin
                    m_frame = 0;
                    m_phase = (m_phase == 3) ? 0 : m_phase + 1;
                end else m_frame++;
            end
            m_vprev = p.vs;
        end
        exp_q.push_back(e);
    endtask

    task automatic dots(inout px_t s[$], input logic en);
        for (int c = 6; c <= 10; c++) s.push_back(mk(XPOS + 11'(8 * c + 4), YPOS + 11'd15, 1'b0, 1'b0, 1'b0, en));
    endtask

    task automatic pulse(inout px_t s[$], input logic en);
        s.push_back(mk(11'd0, 11'd600, 1'b1, 1'b1, 1'b1, en));
        s.push_back(mk(11'd0, 11'd601, 1'b1, 1'b1, 1'b0, en));
    endtask

    task automatic test_reset();
        px_t  s[$];
        exp_t e;
        for (int i = 0; i < 12; i++) s.push_back(mk(XPOS + 11'(i * 9), YPOS + 11'(i * 21), 1'b0, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            rst = (i < 3);
            drive_px(s[i], "reset");
            @(posedge clk); #1;
            if (i < 3) begin
                checks++;
                if (rgb_out !== 12'h000 || hcount_out !== 11'd0 || vcount_out !== 11'd0) begin
                    errors++; $display("FAIL reset_outputs rgb=%h hc=%h vc=%h expected all 0", rgb_out, hcount_out, vcount_out);
                end
            end
            if (i == 2) begin
                checks++;
                if (char_xy !== 8'h00 || font_addr !== 11'h000) begin
                    errors++; $display("FAIL reset_addr char_xy=%h font_addr=%h expected 00/000", char_xy, font_addr);
                end
            end
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_char_addr();
        px_t  s[$];
        exp_t e;
        s.push_back(mk(XPOS + 11'd26, YPOS + 11'd37, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++) s.push_back(mk(XPOS + 11'(27 + i * 13), YPOS + 11'(37 + i * 7), 1'b0, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            drive_px(s[i], "char_addr");
            @(posedge clk); #1;
            if (i == 0) begin
                checks++;
                if (char_xy !== 8'h23) begin errors++; $display("FAIL char_xy got %h expected 23", char_xy); end
            end
            if (i == 1) begin
                checks++;
                if (font_addr !== {code_of(8'h23), 4'h5}) begin
                    errors++; $display("FAIL font_addr got %h expected %h", font_addr, {code_of(8'h23), 4'h5});
                end
            end
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_box_edges();
        px_t  s[$];
        exp_t e;
        s.push_back(mk(XPOS + 11'd127, YPOS + 11'd63, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd128, YPOS + 11'd63, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS,           YPOS + 11'd63, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS - 11'd1,   YPOS + 11'd63, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd33,  YPOS - 11'd1,  1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd33,  YPOS + 11'd255, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd33,  YPOS + 11'd256, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd33,  YPOS,          1'b0, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            drive_px(s[i], "box_edge");
            @(posedge clk); #1;
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_blank();
        px_t  s[$];
        exp_t e;
        s.push_back(mk(XPOS + 11'd50, YPOS + 11'd79, 1'b1, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd50, YPOS + 11'd79, 1'b0, 1'b1, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd50, YPOS + 11'd79, 1'b1, 1'b1, 1'b0, 1'b1));
        s.push_back(mk(XPOS + 11'd51, YPOS + 11'd79, 1'b0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(11'd20,        11'd20,        1'b1, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            drive_px(s[i], "blank");
            @(posedge clk); #1;
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_anim();
        px_t  s[$];
        exp_t e;
        for (int r = 0; r <= 8; r++) begin
            dots(s, 1'b1);
            if (r < 8) pulse(s, 1'b1);
        end
        foreach (s[i]) begin
            drive_px(s[i], "anim");
            @(posedge clk); #1;
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        px_t  s[$];
        exp_t e;
        for (int r = 0; r < 4; r++) pulse(s, 1'b1);
        dots(s, 1'b1);
        dots(s, 1'b0);
        s.push_back(mk(XPOS + 11'd100, YPOS + 11'd143, 1'b0, 1'b0, 1'b0, 1'b0));
        pulse(s, 1'b0);
        dots(s, 1'b1);
        pulse(s, 1'b1);
        pulse(s, 1'b1);
        dots(s, 1'b1);
        foreach (s[i]) begin
            drive_px(s[i], "enable_drop");
            @(posedge clk); #1;
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
                checks++;
                if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                    errors++; $display("FAIL %s timing got %h expected %h", e.name,
                        {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
                end
            end
        end
    endtask

    task automatic test_drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (rgb_out !== e.rgb) begin errors++; $display("FAIL %s rgb_out got %h expected %h", e.name, rgb_out, e.rgb); end
            checks++;
            if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== e.tim) begin
                errors++; $display("FAIL %s timing got %h expected %h", e.name,
                    {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, e.tim);
            end
        end
    endtask

    initial begin
        test_reset();
        test_char_addr();
        test_box_edges();
        test_blank();
        test_anim();
        test_enable_drop();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
